sram_device_responder: RTL and testbench
========================================

// Module: sram_device_responder
// PURPOSE
// Clocked responder for the async 16-bit SRAM pin interface driven by the SoC SRAM controller.
// Decodes ce_n/oe_n/we_n/lb_n/ub_n/address, holds a word array, and returns read data on dq
// after a programmable access delay. Commits writes on the rising edge of the write strobe.
// Serves as the on-chip stand-in for the external SRAM and as the controller's verification target.
// PARAMETERS
// ADDR_W          18  address pin width
// MEM_AW          10  log2 of array depth; address_in[MEM_AW-1:0] indexes, upper bits alias
// READ_LATENCY     4  cycles from accepted read (registered ce_n=0,oe_n=0,we_n=1) to dq driven
// HIZ_CYCLES       2  cycles dq stays driven after ce_n or oe_n deasserts
// MIN_WE_CYCLES    3  minimum registered we_n-low cycles for a legal write
// PORTS
// clk            in   1       single clock
// rst            in   1       synchronous, active-high reset
// address_in     in   ADDR_W  SRAM address pins
// dq             inout 16     data bus; driven only in READ_DRIVE/READ_HIZ, else 'z
// ce_n,oe_n,we_n in   1 each  chip enable, output enable, write enable (active low)
// lb_n,ub_n      in   1 each  byte lanes dq[7:0] / dq[15:8] (active low)
// err_clr        in   1       clears protocol_err
// busy           out  1       state != IDLE
// rd_data_valid  out  1       high in READ_DRIVE
// wr_commit      out  1       one-cycle pulse on array write
// protocol_err   out  1       sticky timing-violation flag
// BEHAVIOUR
// - All pin inputs registered once; FSM acts on registered copies (1-cycle input latency).
// - Reset: state IDLE, dq 'z, busy/rd_data_valid/wr_commit/protocol_err 0, counters 0.
//   Array contents untouched. Reset mid-write: no commit; mid-read: dq to 'z next cycle.
// - States: IDLE, READ_ACCESS, READ_DRIVE, READ_HIZ, WRITE_PULSE.
// - IDLE: ce_n=0 & we_n=0 -> WRITE_PULSE (write wins over oe_n); ce_n=0 & oe_n=0 & we_n=1
//   -> READ_ACCESS, latch addr, cnt=1; else stay.
// - READ_ACCESS: cnt++; cnt==READ_LATENCY -> READ_DRIVE. ce_n/oe_n high -> IDLE, no drive.
// - READ_DRIVE: dq lane driven from mem[addr] when its lb_n/ub_n=0, lane 'z otherwise
//   (lane enables tracked live). Address change -> READ_ACCESS, dq 'z, cnt=1 (re-access).
//   we_n=0 -> protocol_err=1, dq 'z, -> WRITE_PULSE. ce_n or oe_n high -> READ_HIZ, cnt=1.
// - READ_HIZ: keeps driving last data; cnt==HIZ_CYCLES -> IDLE, dq 'z. New read request
//   here is ignored until IDLE.
// - WRITE_PULSE: latch addr on entry; cnt++ (saturate 8 bits); dq and lane enables sampled
//   each cycle, last sample before strobe release wins. Address change -> protocol_err=1,
//   abort, stay until we_n high then IDLE.
//   Release (we_n or ce_n high): cnt>=MIN_WE_CYCLES -> write enabled lanes of mem[addr],
//   wr_commit=1 for one cycle, -> IDLE; else protocol_err=1, no write, -> IDLE.
// - Both lanes disabled on commit: wr_commit still pulses, array unchanged.
// - protocol_err: set by violations, cleared only by err_clr or rst; set wins over clear
//   in the same cycle.
// TESTING
// - Write 0xA5C3 to addr 0x00012, we_n low 4 cycles -> wr_commit pulse; read back gives
//   dq=0xA5C3 exactly READ_LATENCY+1 cycles after ce_n/oe_n low.
// - ub_n=1, lb_n=0 write 0xFFFF over 0xA5C3 -> word 0xA5FF; read with ub_n=1 -> dq[15:8]='z.
// - we_n low 2 cycles -> protocol_err=1, no wr_commit, array unchanged; err_clr -> 0.
// - Addr 0x00400 and 0x00000 alias (MEM_AW=10): write one, read other returns same data.
// - Address change 0x10->0x11 in READ_DRIVE -> dq 'z, rd_data_valid 0, valid again with
//   mem[0x11] READ_LATENCY cycles later; oe_n high -> dq driven 2 more cycles then 'z.
// - rst asserted mid-WRITE_PULSE -> no commit, busy 0, dq 'z next cycle.

Source files
------------

// File: rtl/sram_device_responder_if.sv
// SRAM pin bundle between the SoC SRAM controller (master) and the responder (slave).
// The bidirectional dq bus stays a plain inout on the responder.
interface sram_device_responder_if #(
    parameter int ADDR_W = 18
);
    logic [ADDR_W-1:0] address_in;
    logic              ce_n;
    logic              oe_n;
    logic              we_n;
    logic              lb_n;
    logic              ub_n;

    modport master (output address_in, ce_n, oe_n, we_n, lb_n, ub_n);
    modport slave  (input  address_in, ce_n, oe_n, we_n, lb_n, ub_n);
endinterface

// File: rtl/sram_device_responder.sv
// Clocked stand-in for an async 16-bit SRAM: registered pin decode, programmable read
// access delay, write committed on strobe release, sticky protocol-error flag.
module sram_device_responder #(
    parameter int ADDR_W        = 18,
    parameter int MEM_AW        = 10,
    parameter int READ_LATENCY  = 4,
    parameter int HIZ_CYCLES    = 2,
    parameter int MIN_WE_CYCLES = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    sram_device_responder_if.slave  pins,
    inout  wire  [15:0]             dq,
    input  logic                    err_clr,
    output logic                    busy,
    output logic                    rd_data_valid,
    output logic                    wr_commit,
    output logic                    protocol_err
);
    localparam logic [7:0] RD_LAT = 8'(READ_LATENCY);
    localparam logic [7:0] HZ_LEN = 8'(HIZ_CYCLES);
    localparam logic [7:0] WE_MIN = 8'(MIN_WE_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        READ_ACCESS,
        READ_DRIVE,
        READ_HIZ,
        WRITE_PULSE
    } state_t;

    state_t state, state_d;

    logic [ADDR_W-1:0] addr_q, addr_lat;
    logic              ce_q, oe_q, we_q, lb_q, ub_q;
    logic [15:0]       dq_q, wdata, rd_word;
    logic              wr_lb, wr_ub;
    logic [7:0]        cnt, cnt_d, cnt_inc;
    logic              aborted, aborted_d;
    logic              latch_addr, sample_wr, do_commit, err_set;
    logic              drive;

    logic [15:0] mem [0:(1<<MEM_AW)-1];

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_comb begin
        cnt_inc    = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
        state_d    = state;
        cnt_d      = cnt;
        aborted_d  = aborted;
        latch_addr = 1'b0;
        sample_wr  = 1'b0;
        do_commit  = 1'b0;
        err_set    = 1'b0;
        unique case (state)
            IDLE: begin
                if (!ce_q && !we_q) begin
                    state_d    = WRITE_PULSE;
                    latch_addr = 1'b1;
                    sample_wr  = 1'b1;
                    cnt_d      = 8'd1;
                    aborted_d  = 1'b0;
                end else if (!ce_q && !oe_q) begin
                    state_d    = READ_ACCESS;
                    latch_addr = 1'b1;
                    cnt_d      = 8'd1;
                end
            end
            READ_ACCESS: begin
                if (ce_q || oe_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc >= RD_LAT) state_d = READ_DRIVE;
                end
            end
            READ_DRIVE: begin
                if (!we_q) begin
                    err_set    = 1'b1;
                    state_d    = WRITE_PULSE;
                    latch_addr = 1'b1;
                    sample_wr  = 1'b1;
                    cnt_d      = 8'd1;
                    aborted_d  = 1'b0;
                end else if (ce_q || oe_q) begin
                    state_d = READ_HIZ;
                    cnt_d   = 8'd1;
                end else if (addr_q != addr_lat) begin
                    state_d    = READ_ACCESS;
                    latch_addr = 1'b1;
                    cnt_d      = 8'd1;
                end
            end
            READ_HIZ: begin
                if (cnt >= HZ_LEN) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            WRITE_PULSE: begin
                // An aborted write waits for we_n alone; ce_n release does not end it.
                if (aborted) begin
                    if (we_q) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end else if (we_q || ce_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    if (cnt >= WE_MIN) do_commit = 1'b1;
                    else               err_set   = 1'b1;
                end else if (addr_q != addr_lat) begin
                    err_set   = 1'b1;
                    aborted_d = 1'b1;
                end else begin
                    cnt_d     = cnt_inc;
                    sample_wr = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        busy          = (state != IDLE);
        rd_data_valid = (state == READ_DRIVE);
        drive         = (state == READ_DRIVE) || (state == READ_HIZ);
    end

    assign dq[7:0]  = (drive && !lb_q) ? rd_word[7:0]  : 'z;
    assign dq[15:8] = (drive && !ub_q) ? rd_word[15:8] : 'z;

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q       <= '0;
            ce_q         <= 1'b1;
            oe_q         <= 1'b1;
            we_q         <= 1'b1;
            lb_q         <= 1'b1;
            ub_q         <= 1'b1;
            dq_q         <= '0;
            addr_lat     <= '0;
            wdata        <= '0;
            wr_lb        <= 1'b0;
            wr_ub        <= 1'b0;
            rd_word      <= '0;
            cnt          <= '0;
            aborted      <= 1'b0;
            wr_commit    <= 1'b0;
            protocol_err <= 1'b0;
        end else begin
            addr_q  <= pins.address_in;
            ce_q    <= pins.ce_n;
            oe_q    <= pins.oe_n;
            we_q    <= pins.we_n;
            lb_q    <= pins.lb_n;
            ub_q    <= pins.ub_n;
            dq_q    <= dq;
            cnt     <= cnt_d;
            aborted <= aborted_d;
            if (latch_addr) addr_lat <= addr_q;
            if (sample_wr) begin
                wdata <= dq_q;
                wr_lb <= !lb_q;
                wr_ub <= !ub_q;
            end
            if (state == READ_ACCESS || state == READ_DRIVE)
                rd_word <= mem[addr_lat[MEM_AW-1:0]];
            wr_commit <= do_commit;
            if (err_set)      protocol_err <= 1'b1;
            else if (err_clr) protocol_err <= 1'b0;
        end
    end

    // Array has no reset: contents survive rst.
    always_ff @(posedge clk) begin
        if (!rst && do_commit) begin
            if (wr_lb) mem[addr_lat[MEM_AW-1:0]][7:0]  <= wdata[7:0];
            if (wr_ub) mem[addr_lat[MEM_AW-1:0]][15:8] <= wdata[15:8];
        end
    end
endmodule

// File: tb/tb_sram_device_responder.sv
// Directed bench for sram_device_responder; dq is pulled high so an undriven lane reads 0xFF.
module tb_sram_device_responder;
    localparam int RL = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        err_clr;
    logic        busy, rd_data_valid, wr_commit, protocol_err;
    logic [15:0] tb_dq;
    logic        tb_dq_en;
    tri1  [15:0] dq;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    sram_device_responder_if #(.ADDR_W(18)) pins_if ();

    assign dq = tb_dq_en ? tb_dq : 'z;

    sram_device_responder #(
        .ADDR_W(18), .MEM_AW(10), .READ_LATENCY(RL), .HIZ_CYCLES(2), .MIN_WE_CYCLES(3)
    ) dut (
        .clk(clk), .rst(rst), .pins(pins_if), .dq(dq), .err_clr(err_clr),
        .busy(busy), .rd_data_valid(rd_data_valid), .wr_commit(wr_commit),
        .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [17:0] a, input logic [15:0] d, input logic lbn,
                            input logic ubn, input int unsigned n, input logic exp_commit,
                            input logic exp_err, input string tag);
        pins_if.address_in = a;
        pins_if.lb_n = lbn;
        pins_if.ub_n = ubn;
        pins_if.ce_n = 1'b0;
        pins_if.we_n = 1'b0;
        tb_dq = d;
        tb_dq_en = 1'b1;
        repeat (n) step();
        pins_if.ce_n = 1'b1;
        pins_if.we_n = 1'b1;
        tb_dq_en = 1'b0;
        step();
        check({tag, "_commit_early"}, 16'(wr_commit), 16'd0);
        step();
        check({tag, "_commit"}, 16'(wr_commit), 16'(exp_commit));
        check({tag, "_err"}, 16'(protocol_err), 16'(exp_err));
        check({tag, "_busy"}, 16'(busy), 16'd0);
        step();
        check({tag, "_commit_pulse"}, 16'(wr_commit), 16'd0);
    endtask

    task automatic do_read(input logic [17:0] a, input logic lbn, input logic ubn,
                           input logic [15:0] exp, input string tag);
        pins_if.address_in = a;
        pins_if.lb_n = lbn;
        pins_if.ub_n = ubn;
        pins_if.ce_n = 1'b0;
        pins_if.oe_n = 1'b0;
        pins_if.we_n = 1'b1;
        repeat (RL) step();
        check({tag, "_valid_early"}, 16'(rd_data_valid), 16'd0);
        step();
        check({tag, "_valid"}, 16'(rd_data_valid), 16'd1);
        check({tag, "_dq"}, dq, exp);
    endtask

    task automatic end_read(input logic [15:0] exp, input string tag);
        pins_if.ce_n = 1'b1;
        pins_if.oe_n = 1'b1;
        step();
        check({tag, "_valid_hold"}, 16'(rd_data_valid), 16'd1);
        step();
        check({tag, "_hiz_valid"}, 16'(rd_data_valid), 16'd0);
        check({tag, "_hiz_dq1"}, dq, exp);
        step();
        check({tag, "_hiz_dq2"}, dq, exp);
        step();
        check({tag, "_hiz_off"}, dq, 16'hFFFF);
        check({tag, "_idle"}, 16'(busy), 16'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        err_clr = 1'b0;
        tb_dq = '0;
        tb_dq_en = 1'b0;
        pins_if.address_in = '0;
        pins_if.ce_n = 1'b1;
        pins_if.oe_n = 1'b1;
        pins_if.we_n = 1'b1;
        pins_if.lb_n = 1'b0;
        pins_if.ub_n = 1'b0;
        repeat (3) step();
        check("rst_busy", 16'(busy), 16'd0);
        check("rst_valid", 16'(rd_data_valid), 16'd0);
        check("rst_commit", 16'(wr_commit), 16'd0);
        check("rst_err", 16'(protocol_err), 16'd0);
        check("rst_dq", dq, 16'hFFFF);
        rst = 1'b0;
        step();

        do_write(18'h00012, 16'hA5C3, 1'b0, 1'b0, 4, 1'b1, 1'b0, "wr_a5c3");
        do_read(18'h00012, 1'b0, 1'b0, 16'hA5C3, "rd_a5c3");
        end_read(16'hA5C3, "rd_a5c3");

        do_write(18'h00012, 16'hFFFF, 1'b0, 1'b1, 4, 1'b1, 1'b0, "wr_lb_only");
        do_read(18'h00012, 1'b0, 1'b0, 16'hA5FF, "rd_merged");
        end_read(16'hA5FF, "rd_merged");
        do_read(18'h00012, 1'b0, 1'b1, 16'hFFFF, "rd_ub_off");
        end_read(16'hFFFF, "rd_ub_off");

        do_write(18'h00012, 16'h0000, 1'b0, 1'b0, 2, 1'b0, 1'b1, "wr_short");
        do_read(18'h00012, 1'b0, 1'b0, 16'hA5FF, "rd_after_short");
        end_read(16'hA5FF, "rd_after_short");
        check("err_sticky", 16'(protocol_err), 16'd1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("err_clr", 16'(protocol_err), 16'd0);

        do_write(18'h00400, 16'h1234, 1'b0, 1'b0, 3, 1'b1, 1'b0, "wr_alias_min");
        do_read(18'h00000, 1'b0, 1'b0, 16'h1234, "rd_alias");
        end_read(16'h1234, "rd_alias");

        do_write(18'h00010, 16'h3C3C, 1'b0, 1'b0, 4, 1'b1, 1'b0, "wr_10");
        do_write(18'h00011, 16'h5A0F, 1'b0, 1'b0, 4, 1'b1, 1'b0, "wr_11");
        do_read(18'h00010, 1'b0, 1'b0, 16'h3C3C, "rd_10");
        pins_if.address_in = 18'h00011;
        step();
        check("rechg_old_valid", 16'(rd_data_valid), 16'd1);
        check("rechg_old_dq", dq, 16'h3C3C);
        step();
        check("rechg_valid_drop", 16'(rd_data_valid), 16'd0);
        check("rechg_dq_off", dq, 16'hFFFF);
        repeat (2) step();
        check("rechg_valid_early", 16'(rd_data_valid), 16'd0);
        step();
        check("rechg_valid", 16'(rd_data_valid), 16'd1);
        check("rechg_dq", dq, 16'h5A0F);
        end_read(16'h5A0F, "rd_11");

        do_read(18'h00011, 1'b0, 1'b0, 16'h5A0F, "rd_pre_rst");
        rst = 1'b1;
        step();
        check("rst_rd_dq", dq, 16'hFFFF);
        check("rst_rd_valid", 16'(rd_data_valid), 16'd0);
        pins_if.ce_n = 1'b1;
        pins_if.oe_n = 1'b1;
        step();
        rst = 1'b0;
        step();

        pins_if.address_in = 18'h00012;
        pins_if.lb_n = 1'b0;
        pins_if.ub_n = 1'b0;
        pins_if.ce_n = 1'b0;
        pins_if.we_n = 1'b0;
        tb_dq = 16'h0F0F;
        tb_dq_en = 1'b1;
        repeat (4) step();
        check("wr_rst_busy_pre", 16'(busy), 16'd1);
        rst = 1'b1;
        pins_if.ce_n = 1'b1;
        pins_if.we_n = 1'b1;
        tb_dq_en = 1'b0;
        step();
        check("wr_rst_busy", 16'(busy), 16'd0);
        check("wr_rst_commit", 16'(wr_commit), 16'd0);
        check("wr_rst_dq", dq, 16'hFFFF);
        rst = 1'b0;
        step();
        check("wr_rst_commit_after", 16'(wr_commit), 16'd0);
        do_read(18'h00012, 1'b0, 1'b0, 16'hA5FF, "rd_after_rst");
        end_read(16'hA5FF, "rd_after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
